effects_job_scheduler: RTL and testbench
========================================

// Module: effects_job_scheduler
// PURPOSE
//  Round-robin scheduler that shares one pixel-effects engine between NUM_REQ
//  requesters. Accepts effect jobs, launches the engine with a start pulse and
//  effect code, watches the engine's done flag with a watchdog, and returns a
//  completion (or timeout error) tagged with the requester id.
// PARAMETERS
//  NUM_REQ  4     number of requesters (>=2); ID_W = $clog2(NUM_REQ)
//  TIMEOUT  1000  max RUN cycles before a job is aborted (engine frame = 900 px)
//  TMR_W    16    watchdog timer width; TIMEOUT must be < 2**TMR_W
// PORTS
//  clk        in   1           clock
//  rst        in   1           synchronous, active-high reset
//  enable     in   1           1 = grants allowed; 0 = finish current job, grant no more
//  req        in   NUM_REQ     per-requester job request, held until gnt
//  req_eff    in   2*NUM_REQ   effect code of requester i at [2i+1:2i], held with req
//  gnt        out  NUM_REQ     one-hot, 1-cycle accept pulse
//  eng_start  out  1           1-cycle start pulse to engine
//  eng_eff    out  2           effect selector to engine, stable for whole job
//  eng_done   in   1           engine done (also high while engine idle)
//  cmp_valid  out  1           1-cycle job completion pulse
//  cmp_id     out  ID_W        requester id of completed job
//  cmp_err    out  1           1 = job aborted by watchdog (qualified by cmp_valid)
//  busy       out  1           high in every state except IDLE
//  jobs_done  out  16          count of error-free completions, saturates at 16'hFFFF
// BEHAVIOUR
//  - All outputs registered. Reset: gnt=0, eng_start=0, eng_eff=0, cmp_valid=0,
//    cmp_id=0, cmp_err=0, busy=0, jobs_done=0, rr_ptr=0, timer=0, state=IDLE.
//  - FSM states: IDLE -> LAUNCH -> RUN -> REPORT -> IDLE.
//  - IDLE: if enable && |req, winner = first i with req[i] searching
//    rr_ptr, rr_ptr+1, ... mod NUM_REQ. Latch winner id and req_eff of winner;
//    rr_ptr <= (winner+1) mod NUM_REQ; go LAUNCH. No req or enable low: stay.
//    eng_done ignored in IDLE.
//  - LAUNCH (exactly 1 cycle): gnt[winner]=1, eng_start=1, eng_eff=latched code,
//    busy=1, timer cleared; next RUN. Grant latency: req seen in IDLE cycle N ->
//    gnt/eng_start high in cycle N+1.
//  - RUN: eng_start=0, eng_eff held; timer += 1 per cycle. eng_done sampled from
//    the first RUN cycle (engine drives done=0 there while active).
//    eng_done=1 -> REPORT with err=0. Else timer==TIMEOUT-1 -> REPORT with err=1.
//    If both in same cycle, done wins (err=0).
//  - REPORT (1 cycle): cmp_valid=1, cmp_id=latched id, cmp_err=err;
//    jobs_done += 1 if err=0 and not saturated; next IDLE (busy=0 following cycle).
//  - Minimum job-to-job spacing: REPORT -> IDLE -> LAUNCH, i.e. one IDLE cycle
//    between a completion and the next eng_start.
//  - enable deassert in LAUNCH/RUN/REPORT: current job completes normally.
//  - req dropped before its grant: not granted; req rising while busy: waits.
//  - Changes to req_eff after the arbitration cycle have no effect on the job.
//  - rst mid-job: FSM to IDLE next cycle, all outputs to reset values, no
//    cmp_valid for the aborted job; engine is reset by the same rst.
//  - Timeout does not reset the engine; scheduler relies on engine idle
//    (done=1) before next LAUNCH only through the mandatory IDLE cycle.
//  - cmp_id and cmp_err hold their last value outside REPORT.
// TESTING
//  1 req=4'b0001, req_eff[1:0]=2'd1, engine model done after 900 cycles ->
//    gnt=0001 & eng_start one cycle after req, eng_eff=1 held, cmp_valid id=0 err=0,
//    jobs_done=1.
//  2 req=4'b1111 held, codes 0..3 -> grant order 0,1,2,3,0; eng_eff matches each;
//    exactly one IDLE cycle between each cmp_valid and next eng_start.
//  3 TIMEOUT=50, engine never asserts done -> cmp_valid with err=1 after 50 RUN
//    cycles, jobs_done unchanged, next request then granted normally.
//  4 rst asserted at RUN cycle 300 -> next cycle busy=0, eng_start=0, gnt=0,
//    no cmp_valid; rr_ptr=0 so req=4'b1010 afterwards grants requester 1.
//  5 enable=0 during RUN with req=4'b0100 pending -> current job completes,
//    no gnt until enable=1, then gnt=0100.
//  6 eng_done=1 in IDLE, and done+timeout same cycle -> no spurious cmp_valid;
//    coincident case reports err=0.

Source files
------------

// File: rtl/effects_job_scheduler.sv
// Round-robin scheduler sharing one pixel-effects engine between NUM_REQ requesters.
// Launches each job with a start pulse, watches done with a watchdog, reports completion.
module effects_job_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1000,
    parameter int TMR_W   = 16,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_eff,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 eng_start,
    output logic [1:0]           eng_eff,
    input  logic                 eng_done,
    output logic                 cmp_valid,
    output logic [ID_W-1:0]      cmp_id,
    output logic                 cmp_err,
    output logic                 busy,
    output logic [15:0]          jobs_done,
    output logic [1:0]           fsm_state
);

    // Handshake: req[i] is held until gnt[i] pulses for one cycle; gnt marks acceptance.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [ID_W-1:0]    rr_ptr, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [TMR_W-1:0]   timer, timer_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic               start_d;
    logic [1:0]         eff_d;
    logic               cmp_valid_d;
    logic [ID_W-1:0]    cmp_id_d;
    logic               cmp_err_d;
    logic               busy_d;
    logic [15:0]        jobs_d;

    logic               found;
    logic [ID_W-1:0]    win;
    int                 win_idx;
    int                 idx;

    assign fsm_state = state;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_idx = 0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = idx;
                win     = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state;
        rr_d        = rr_ptr;
        id_d        = id_q;
        timer_d     = timer;
        gnt_d       = '0;
        start_d     = 1'b0;
        eff_d       = eng_eff;
        cmp_valid_d = 1'b0;
        cmp_id_d    = cmp_id;
        cmp_err_d   = cmp_err;
        jobs_d      = jobs_done;
        case (state)
            IDLE: begin
                if (enable && found) begin
                    state_d        = LAUNCH;
                    id_d           = win;
                    eff_d          = req_eff[2*win_idx +: 2];
                    rr_d           = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
                    gnt_d[win_idx] = 1'b1;
                    start_d        = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = RUN;
                timer_d = '0;
            end
            RUN: begin
                timer_d = timer + 1'b1;
                // A done flag arriving on the last allowed cycle still counts as success.
                if (eng_done) begin
                    state_d     = REPORT;
                    cmp_valid_d = 1'b1;
                    cmp_id_d    = id_q;
                    cmp_err_d   = 1'b0;
                    if (jobs_done != 16'hFFFF)
                        jobs_d = jobs_done + 16'd1;
                end else if (timer == TMR_W'(TIMEOUT-1)) begin
                    state_d     = REPORT;
                    cmp_valid_d = 1'b1;
                    cmp_id_d    = id_q;
                    cmp_err_d   = 1'b1;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            timer     <= '0;
            gnt       <= '0;
            eng_start <= 1'b0;
            eng_eff   <= 2'd0;
            cmp_valid <= 1'b0;
            cmp_id    <= '0;
            cmp_err   <= 1'b0;
            busy      <= 1'b0;
            jobs_done <= 16'd0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_d;
            id_q      <= id_d;
            timer     <= timer_d;
            gnt       <= gnt_d;
            eng_start <= start_d;
            eng_eff   <= eff_d;
            cmp_valid <= cmp_valid_d;
            cmp_id    <= cmp_id_d;
            cmp_err   <= cmp_err_d;
            busy      <= busy_d;
            jobs_done <= jobs_d;
        end
    end

endmodule

// File: tb/tb_effects_job_scheduler.sv
// Directed, table-driven bench for effects_job_scheduler with a behavioural engine model.
module tb_effects_job_scheduler;

    localparam int TB_TIMEOUT = 1000;
    localparam int HANG       = 100000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  req_eff = '0;
    logic [3:0]  gnt;
    logic        eng_start;
    logic [1:0]  eng_eff;
    logic        eng_done = 1'b1;
    logic        cmp_valid;
    logic [1:0]  cmp_id;
    logic        cmp_err;
    logic        busy;
    logic [15:0] jobs_done;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int launch_cyc = 0;
    int cmp_cyc = 0;
    int done_delay = 5;

    effects_job_scheduler #(
        .NUM_REQ (4),
        .TIMEOUT (TB_TIMEOUT),
        .TMR_W   (16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .req       (req),
        .req_eff   (req_eff),
        .gnt       (gnt),
        .eng_start (eng_start),
        .eng_eff   (eng_eff),
        .eng_done  (eng_done),
        .cmp_valid (cmp_valid),
        .cmp_id    (cmp_id),
        .cmp_err   (cmp_err),
        .busy      (busy),
        .jobs_done (jobs_done),
        .fsm_state (fsm_state)
    );

    // clock / reset timebase
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: done low from the start pulse, high again in RUN cycle done_delay.
    int eng_cnt = 0;
    int eng_target = 0;
    bit eng_active = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            eng_done   = 1'b1;
            eng_active = 1'b0;
            eng_cnt    = 0;
        end else if (eng_start) begin
            eng_done   = 1'b0;
            eng_active = 1'b1;
            eng_cnt    = 0;
            eng_target = done_delay;
        end else if (eng_active) begin
            if (eng_cnt == eng_target) begin
                eng_done   = 1'b1;
                eng_active = 1'b0;
            end else begin
                eng_cnt++;
            end
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  eff;
        int          delay;
        bit          scramble;
        logic [3:0]  exp_gnt;
        logic [1:0]  exp_eff;
        logic [1:0]  exp_id;
        bit          exp_err;
        logic [15:0] exp_jobs;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_launch(input int max, output bit ok, output bit saw_cmp);
        int k;
        ok = 1'b0;
        saw_cmp = 1'b0;
        k = 0;
        while (!ok && k < max) begin
            @(negedge clk);
            if (cmp_valid) saw_cmp = 1'b1;
            if (eng_start) begin
                ok = 1'b1;
                launch_cyc = cyc;
            end
            k++;
        end
    endtask

    task automatic wait_cmp(input int max, input logic [1:0] exp_eff,
                            output bit ok, output bit eff_stable, output bit extra_gnt);
        int k;
        ok = 1'b0;
        eff_stable = 1'b1;
        extra_gnt = 1'b0;
        k = 0;
        while (!ok && k < max) begin
            @(negedge clk);
            if (eng_eff !== exp_eff) eff_stable = 1'b0;
            if (gnt !== 4'b0 || eng_start !== 1'b0) extra_gnt = 1'b1;
            if (cmp_valid) begin
                ok = 1'b1;
                cmp_cyc = cyc;
            end
            k++;
        end
    endtask

    task automatic idle_quiet(input int n, output bit quiet);
        quiet = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (gnt !== 4'b0 || eng_start || cmp_valid || busy) quiet = 1'b0;
        end
    endtask

    initial begin
        bit ok, saw, stable, extra, quiet;
        int exp_lat;

        vecs[0]  = '{4'b1111, 8'hE4, 5,    1'b0, 4'b0001, 2'd0, 2'd0, 1'b0, 16'd1};
        vecs[1]  = '{4'b1111, 8'hE4, 3,    1'b0, 4'b0010, 2'd1, 2'd1, 1'b0, 16'd2};
        vecs[2]  = '{4'b1111, 8'hE4, 7,    1'b0, 4'b0100, 2'd2, 2'd2, 1'b0, 16'd3};
        vecs[3]  = '{4'b1111, 8'hE4, 1,    1'b0, 4'b1000, 2'd3, 2'd3, 1'b0, 16'd4};
        vecs[4]  = '{4'b1111, 8'hE4, 10,   1'b0, 4'b0001, 2'd0, 2'd0, 1'b0, 16'd5};
        vecs[5]  = '{4'b0001, 8'h01, 900,  1'b0, 4'b0001, 2'd1, 2'd0, 1'b0, 16'd6};
        vecs[6]  = '{4'b0010, 8'h08, HANG, 1'b1, 4'b0010, 2'd2, 2'd1, 1'b1, 16'd6};
        vecs[7]  = '{4'b1000, 8'hC0, 20,   1'b0, 4'b1000, 2'd3, 2'd3, 1'b0, 16'd7};
        vecs[8]  = '{4'b0100, 8'h10, 999,  1'b0, 4'b0100, 2'd1, 2'd2, 1'b0, 16'd8};
        vecs[9]  = '{4'b0011, 8'h0E, 4,    1'b0, 4'b0001, 2'd2, 2'd0, 1'b0, 16'd9};
        vecs[10] = '{4'b0011, 8'h0E, 6,    1'b0, 4'b0010, 2'd3, 2'd1, 1'b0, 16'd10};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_start", 32'(eng_start), 32'h0);
        check("rst_eff", 32'(eng_eff), 32'h0);
        check("rst_cmp", 32'({cmp_valid, cmp_id, cmp_err}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_jobs", 32'(jobs_done), 32'h0);
        check("rst_state", 32'(fsm_state), 32'h0);
        rst = 1'b0;

        // done high while idle and no request: nothing happens
        idle_quiet(20, quiet);
        check("idle_done_quiet", 32'(quiet), 32'h1);

        req        = vecs[0].req;
        req_eff    = vecs[0].eff;
        done_delay = vecs[0].delay;
        for (int i = 0; i < 11; i++) begin
            wait_launch(10, ok, saw);
            check($sformatf("v%0d_launch", i), 32'(ok), 32'h1);
            if (i > 0) check($sformatf("v%0d_gap", i), 32'(launch_cyc - cmp_cyc), 32'd2);
            check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("v%0d_eff", i), 32'(eng_eff), 32'(vecs[i].exp_eff));
            if (vecs[i].scramble) req_eff = ~vecs[i].eff;
            wait_cmp(TB_TIMEOUT + 20, vecs[i].exp_eff, ok, stable, extra);
            check($sformatf("v%0d_cmp", i), 32'(ok), 32'h1);
            exp_lat = (vecs[i].delay < TB_TIMEOUT) ? vecs[i].delay + 2 : TB_TIMEOUT + 1;
            check($sformatf("v%0d_lat", i), 32'(cmp_cyc - launch_cyc), 32'(exp_lat));
            check($sformatf("v%0d_id", i), 32'(cmp_id), 32'(vecs[i].exp_id));
            check($sformatf("v%0d_err", i), 32'(cmp_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_stable", i), 32'({stable, extra}), 32'h2);
            if (i < 10) begin
                req        = vecs[i+1].req;
                req_eff    = vecs[i+1].eff;
                done_delay = vecs[i+1].delay;
            end else begin
                req = '0;
            end
            @(negedge clk);
            check($sformatf("v%0d_idle", i), 32'({busy, cmp_valid, eng_start}), 32'h0);
            check($sformatf("v%0d_jobs", i), 32'(jobs_done), 32'(vecs[i].exp_jobs));
        end

        // enable low mid-job; requester 1 drops its request before being served
        done_delay = 50;
        req_eff    = 8'h03;
        req        = 4'b0001;
        wait_launch(10, ok, saw);
        check("en_launch", 32'({ok, gnt}), 32'h11);
        check("en_eff", 32'(eng_eff), 32'h3);
        req = '0;
        repeat (5) @(negedge clk);
        req = 4'b0110;
        repeat (5) @(negedge clk);
        req    = 4'b0100;
        enable = 1'b0;
        wait_cmp(100, 2'd3, ok, stable, extra);
        check("en_cmp", 32'({ok, cmp_id, cmp_err}), 32'h8);
        idle_quiet(20, quiet);
        check("en_hold_quiet", 32'(quiet), 32'h1);
        check("en_jobs", 32'(jobs_done), 32'd11);
        done_delay = 5;
        enable     = 1'b1;
        wait_launch(10, ok, saw);
        check("en_regrant", 32'({ok, gnt}), 32'h14);
        req = '0;
        wait_cmp(20, 2'd0, ok, stable, extra);
        check("en_cmp2", 32'({ok, cmp_id, cmp_err}), 32'hC);

        // reset in the middle of a hung job
        done_delay = HANG;
        req_eff    = 8'h80;
        req        = 4'b1000;
        wait_launch(10, ok, saw);
        check("rr_launch", 32'({ok, gnt}), 32'h18);
        req = '0;
        saw = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (cmp_valid) saw = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outs", 32'({saw, busy, eng_start, gnt, cmp_valid}), 32'h0);
        check("midrst_jobs", 32'(jobs_done), 32'h0);
        check("midrst_state", 32'(fsm_state), 32'h0);
        rst        = 1'b0;
        done_delay = 8;
        req_eff    = 8'h04;
        req        = 4'b1010;
        wait_launch(10, ok, saw);
        check("postrst_launch", 32'({saw, ok, gnt}), 32'h12);
        check("postrst_eff", 32'(eng_eff), 32'h1);
        req = '0;
        wait_cmp(20, 2'd1, ok, stable, extra);
        check("postrst_cmp", 32'({ok, cmp_id, cmp_err}), 32'hA);
        @(negedge clk);
        check("postrst_jobs", 32'(jobs_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
